// File: rtl/vector_pkg.sv
// Shared vector-unit types: fp16 scalar type, reduction opcodes, special fp16
// encodings and the per-op identity element used to pad masked lanes.
package vector_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    RED_MAX     = 2'b00,
    RED_MIN     = 2'b01,
    RED_SUM     = 2'b10,
    RED_ILLEGAL = 2'b11
  } reduction_op;

  localparam fp16_t FP16_POS_INF  = 16'h7C00;
  localparam fp16_t FP16_NEG_INF  = 16'hFC00;
  localparam fp16_t FP16_NEG_ZERO = 16'h8000;
  localparam fp16_t FP16_QNAN     = 16'h7E00;

  // Value that leaves the accumulator unchanged when fed through the ALU.
  function automatic fp16_t identity_of(input reduction_op op);
    fp16_t id;
    case (op)
      RED_MAX: id = FP16_NEG_INF;
      RED_MIN: id = FP16_POS_INF;
      RED_SUM: id = FP16_NEG_ZERO;
      default: id = FP16_QNAN;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/vreduction_seq.sv
// Reduction sequencer: buffers one masked fp16 vector and walks it lane by lane
// through an external combinational ALU, returning a single scalar result.
module vreduction_seq
  import vector_pkg::*;
#(
  parameter int LANES = 16,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [LANES-1:0]    lane_mask,
  input  logic [LANES*16-1:0] vec_in,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         result,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [1:0]          alu_op,
  input  logic [15:0]         alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  fp16_t       acc_q, acc_d;
  fp16_t       result_q, result_d;
  reduction_op op_q, op_d;
  fp16_t       lane_buf_q [LANES];
  fp16_t       lane_buf_d [LANES];
  fp16_t       masked_in  [LANES];

  // Masked lanes become the identity so the RUN loop never needs the mask.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign masked_in[gi] = lane_mask[gi] ? vec_in[gi*16 +: 16]
                                           : identity_of(reduction_op'(op));
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    result_d   = result_q;
    op_d       = op_q;
    lane_buf_d = lane_buf_q;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = op_q;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_d       = reduction_op'(op);
          lane_buf_d = masked_in;
          idx_d      = IDXW'(1);
          if (reduction_op'(op) == RED_ILLEGAL) begin
            acc_d    = FP16_QNAN;
            result_d = FP16_QNAN;
            state_d  = S_FIN;
          end else begin
            acc_d   = masked_in[0];
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_a = acc_q;
        alu_b = lane_buf_q[idx_q];
        acc_d = alu_out;
        // Final lane: capture the result now so it is valid alongside done.
        if (idx_q == IDXW'(LANES-1)) begin
          result_d = alu_out;
          state_d  = S_FIN;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_FIN: begin
        done    = 1'b1;
        err     = (op_q == RED_ILLEGAL);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      op_q     <= RED_MAX;
      for (int i = 0; i < LANES; i++) lane_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      op_q       <= op_d;
      lane_buf_q <= lane_buf_d;
    end
  end

  assign result = result_q;

endmodule
